// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network activation blocks.
//   NN_DATA_W : default signed sample width
//   id_width  : lane-id width for a given requester count (minimum 1 bit)
//   relu_f    : max(x, 0) on a signed NN_DATA_W sample
package nn_pkg;

  localparam int NN_DATA_W = 16;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [NN_DATA_W-1:0] relu_f(input logic [NN_DATA_W-1:0] x);
    return x[NN_DATA_W-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker.
// Scans req starting at ptr and wrapping modulo N. The first set bit wins.
//   req       in  N      request vector
//   ptr       in  IDX_W  highest-priority index (must be < N)
//   en        in  1      when low, no grant is issued
//   grant     out N      one-hot grant, or all zero
//   grant_idx out IDX_W  index of the granted bit (0 when there is no grant)
module rr_grant #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic             found;
  int               pos;
  logic [IDX_W-1:0] idx;

  // NOTE: every variable gets a default before any conditional assignment.
  // This keeps the block purely combinational, with no inferred latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      idx = IDX_W'(pos);
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/relu_rr_scheduler.sv
// Shares one ReLU datapath between NUM_REQ lanes.
// Lanes are arbitrated round-robin. Each result is tagged with its source
// lane and buffered in a 2-entry output FIFO. A saturating counter tracks
// how many accepted samples were negative.
//   clk, rst_n      clock, async active-low reset
//   req_valid/ready per-lane handshake (ready is a one-hot grant)
//   req_data        lane i at [i*DATA_W +: DATA_W], signed
//   out_valid/ready output handshake at the FIFO head
//   out_data/out_id ReLU result and its source lane
//   neg_count       saturating count of accepted negative samples
module relu_rr_scheduler
  import nn_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = NN_DATA_W,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [ID_W-1:0]           out_id,
  input  logic                      out_ready,
  output logic [15:0]               neg_count
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
  } entry_t;

  logic [1:0]         fifo_count;
  entry_t             head, tail, new_entry;
  logic [ID_W-1:0]    ptr, grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               can_accept, push, pop;
  logic [DATA_W-1:0]  sel_data, relu_data;

  // rst_n gates the grant so req_ready is low for the whole reset period,
  // not only once the registers have cleared.
  assign can_accept = (fifo_count != 2'd2) && rst_n;

  rr_grant #(.N(NUM_REQ), .IDX_W(ID_W)) u_grant (
    .req       (req_valid),
    .ptr       (ptr),
    .en        (can_accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // A grant is only issued to a valid lane, so any grant is a transfer.
  assign req_ready = grant;
  assign push      = |grant;
  assign pop       = out_valid && out_ready;
  assign sel_data  = req_data[int'(grant_idx)*DATA_W +: DATA_W];

  // The shared relu_f is fixed at the package width.
  // Any other width uses the same rule written inline.
  if (DATA_W == NN_DATA_W) begin : g_pkg_relu
    assign relu_data = relu_f(sel_data);
  end else begin : g_local_relu
    assign relu_data = sel_data[DATA_W-1] ? '0 : sel_data;
  end

  assign new_entry = '{data: relu_data, id: grant_idx};
  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = head.data;
  assign out_id    = head.id;

  // NOTE: the FIFO entries are ordinary registers, not a RAM, so they are
  // cleared by reset. That gives the required zero out_data/out_id at reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // register then samples the pre-edge values of the others.
      ptr        <= '0;
      fifo_count <= '0;
      head       <= '0;
      tail       <= '0;
      neg_count  <= '0;
    end else begin
      if (push) begin
        ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);
        if (sel_data[DATA_W-1] && neg_count != 16'hFFFF)
          neg_count <= neg_count + 16'd1;
      end
      case (fifo_count)
        2'd0: begin
          if (push) begin
            head       <= new_entry;
            fifo_count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= new_entry;
          end else if (push) begin
            tail       <= new_entry;
            fifo_count <= 2'd2;
          end else if (pop) begin
            fifo_count <= 2'd0;
          end
        end
        default: begin
          // A full FIFO issues no grant, so only a pop can occur here.
          if (pop) begin
            head       <= tail;
            fifo_count <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_relu_rr_scheduler.sv
// Directed testbench for relu_rr_scheduler (NUM_REQ=4, DATA_W=16).
// Inputs change 1 time unit after a rising edge.
// Outputs are checked 1 further unit later, well before the next edge.
module tb_relu_rr_scheduler;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_id;
  logic            out_ready;
  logic [15:0]     neg_count;

  int n_cmp = 0;
  int n_err = 0;

  relu_rr_scheduler #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .neg_count (neg_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    req_valid = '1;
    req_data  = '0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #3;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_req_ready got %b want 0000", req_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    n_cmp++;
    if (out_data !== 16'd0 || out_id !== 2'd0) begin
      n_err++;
      $display("FAIL reset_out_data_id got %0d/%0d want 0/0", out_data, out_id);
    end
    n_cmp++;
    if (neg_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_neg_count got %0d want 0", neg_count);
    end
    tick();
  endtask

  task automatic test_single_lane();
    logic [DW-1:0] vin [5];
    logic [DW-1:0] vexp[5];
    vin[0] = 16'd1234;  vexp[0] = 16'd1234;
    vin[1] = 16'hFB2E;  vexp[1] = 16'd0;      // -1234
    vin[2] = 16'h7FFF;  vexp[2] = 16'h7FFF;
    vin[3] = 16'h8000;  vexp[3] = 16'd0;      // -32768
    vin[4] = 16'd0;     vexp[4] = 16'd0;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_valid = 4'b0001;
      req_data  = '0;
      req_data[DW-1:0] = vin[i];
      #1;
      n_cmp++;
      if (req_ready !== 4'b0001) begin
        n_err++;
        $display("FAIL single_ready[%0d] got %b want 0001", i, req_ready);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== vexp[i] || out_id !== 2'd0) begin
        n_err++;
        $display("FAIL single_out[%0d] got v=%b d=%0d id=%0d want v=1 d=%0d id=0",
                 i, out_valid, out_data, out_id, vexp[i]);
      end
    end
    req_valid = '0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || neg_count !== 16'd2) begin
      n_err++;
      $display("FAIL single_end got v=%b neg=%0d want v=0 neg=2", out_valid, neg_count);
    end
  endtask

  task automatic test_fairness();
    logic [IW-1:0] exp_id;
    logic [N-1:0]  exp_gnt;
    apply_reset();
    out_ready = 1'b1;
    for (int l = 0; l < N; l++) req_data[l*DW +: DW] = 16'(100 + l);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp_id  = IW'(k % N);
      exp_gnt = 4'b0001 << exp_id;
      #1;
      n_cmp++;
      if (req_ready !== exp_gnt) begin
        n_err++;
        $display("FAIL fair_grant[%0d] got %b want %b", k, req_ready, exp_gnt);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_id !== exp_id || out_data !== 16'(100 + (k % N))) begin
        n_err++;
        $display("FAIL fair_out[%0d] got id=%0d d=%0d want id=%0d d=%0d",
                 k, out_id, out_data, exp_id, 100 + (k % N));
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_back_to_back_backpressure();
    apply_reset();
    out_ready = 1'b0;
    for (int l = 0; l < N; l++) req_data[l*DW +: DW] = 16'(200 + l);
    req_valid = 4'b1111;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL bp_grant0 got %b want 0001", req_ready);
    end
    tick();
    n_cmp++;
    if (req_ready !== 4'b0010 || out_id !== 2'd0) begin
      n_err++;
      $display("FAIL bp_grant1 got rdy=%b id=%0d want rdy=0010 id=0", req_ready, out_id);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (req_ready !== 4'b0000 || out_valid !== 1'b1 || out_id !== 2'd0 ||
          out_data !== 16'd200) begin
        n_err++;
        $display("FAIL bp_full[%0d] got rdy=%b v=%b id=%0d d=%0d want rdy=0000 v=1 id=0 d=200",
                 c, req_ready, out_valid, out_id, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL bp_pop_full_no_grant got %b want 0000", req_ready);
    end
    tick();
    n_cmp++;
    if (out_id !== 2'd1 || out_data !== 16'd201 || req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL bp_drain1 got id=%0d d=%0d rdy=%b want id=1 d=201 rdy=0100",
               out_id, out_data, req_ready);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== 16'd202) begin
      n_err++;
      $display("FAIL bp_lane2 got v=%b id=%0d d=%0d want v=1 id=2 d=202",
               out_valid, out_id, out_data);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_sparse();
    logic [IW-1:0] seq[7];
    seq[0] = 2'd1; seq[1] = 2'd3; seq[2] = 2'd1; seq[3] = 2'd3;
    seq[4] = 2'd1; seq[5] = 2'd1; seq[6] = 2'd1;
    apply_reset();
    out_ready = 1'b1;
    for (int l = 0; l < N; l++) req_data[l*DW +: DW] = 16'(300 + l);
    for (int k = 0; k < 7; k++) begin
      req_valid = (k < 4) ? 4'b1010 : 4'b0010;
      #1;
      n_cmp++;
      if (req_ready !== (4'b0001 << seq[k])) begin
        n_err++;
        $display("FAIL sparse_grant[%0d] got %b want lane %0d", k, req_ready, seq[k]);
      end
      tick();
      n_cmp++;
      if (out_id !== seq[k]) begin
        n_err++;
        $display("FAIL sparse_out_id[%0d] got %0d want %0d", k, out_id, seq[k]);
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_saturation_and_reset();
    apply_reset();
    out_ready = 1'b1;
    for (int l = 0; l < N; l++) req_data[l*DW +: DW] = 16'hFFFF;   // -1
    req_valid = 4'b0001;
    for (int k = 0; k < 100; k++) tick();
    n_cmp++;
    if (neg_count !== 16'd100) begin
      n_err++;
      $display("FAIL sat_count100 got %0d want 100", neg_count);
    end
    for (int k = 100; k < 65600; k++) tick();
    n_cmp++;
    if (neg_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sat_count got %0d want 65535", neg_count);
    end
    // Fill the FIFO. After lane 0 keeps winning, ptr sits at 1.
    out_ready = 1'b0;
    req_valid = 4'b1111;
    tick();
    tick();
    n_cmp++;
    if (req_ready !== 4'b0000 || out_valid !== 1'b1 || neg_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sat_full got rdy=%b v=%b neg=%0d want rdy=0000 v=1 neg=65535",
               req_ready, out_valid, neg_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || neg_count !== 16'd0 || req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL async_reset got v=%b neg=%0d rdy=%b want v=0 neg=0 rdy=0000",
               out_valid, neg_count, req_ready);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL async_reset_ptr got %b want 0001", req_ready);
    end
    req_valid = '0;
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    #2;
    test_reset();
    test_single_lane();
    test_fairness();
    test_back_to_back_backpressure();
    test_sparse();
    test_saturation_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
